// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI image loader.
package spi_loader_pkg;

    // Frame protocol states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_END = 3'd2,
        COMPUTE  = 3'd3,
        READY    = 3'd4
    } loader_state_t;

    localparam logic [7:0] START_CMD = 8'h00;
    localparam logic [7:0] END_CMD   = 8'hFF;
    localparam logic [7:0] BUSY_BYTE = 8'hFF;

    localparam int NUM_PIXELS = 144;

    // Select the low or high pixel nibble of a received byte
    function automatic logic [3:0] pix_nibble(input logic [7:0] b, input logic hi);
        pix_nibble = hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/spi_image_loader_if.sv
// SPI pins plus pixel-write and classifier handshake of the image loader.
interface spi_image_loader_if;
    logic       SCK;
    logic       SS;
    logic       MOSI;
    logic       MISO;
    logic       pix_we;
    logic [7:0] pix_addr;
    logic [3:0] pix_data;
    logic       start;
    logic       result_valid;
    logic [3:0] result;
    logic       frame_err;

    modport master (
        output SCK, SS, MOSI, result_valid, result,
        input  MISO, pix_we, pix_addr, pix_data, start, frame_err
    );

    modport slave (
        input  SCK, SS, MOSI, result_valid, result,
        output MISO, pix_we, pix_addr, pix_data, start, frame_err
    );
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizes the asynchronous SPI pins into the clk domain and detects
// SCK rise/fall and SS fall/rise. All outputs are registered and aligned:
// an edge on a pin shows up SYNC_STAGES+1 clk later.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_level,
    output logic mosi_level
);

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;

    logic sck_level_r;
    logic ss_level_r;
    logic mosi_level_r;
    logic sck_rise_r;
    logic sck_fall_r;
    logic ss_fall_r;
    logic ss_rise_r;

    // Metastability chains, reset to the idle bus levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sck_sync_r[0]  <= sck;
            ss_sync_r[0]   <= ss;
            mosi_sync_r[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync_r[i]  <= sck_sync_r[i-1];
                ss_sync_r[i]   <= ss_sync_r[i-1];
                mosi_sync_r[i] <= mosi_sync_r[i-1];
            end
        end
    end

    // Edge register: delayed levels double as the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_level_r  <= 1'b0;
            ss_level_r   <= 1'b1;
            mosi_level_r <= 1'b1;
            sck_rise_r   <= 1'b0;
            sck_fall_r   <= 1'b0;
            ss_fall_r    <= 1'b0;
            ss_rise_r    <= 1'b0;
        end else begin
            sck_level_r  <= sck_sync_r[SYNC_STAGES-1];
            ss_level_r   <= ss_sync_r[SYNC_STAGES-1];
            mosi_level_r <= mosi_sync_r[SYNC_STAGES-1];
            sck_rise_r   <=  sck_sync_r[SYNC_STAGES-1] & ~sck_level_r;
            sck_fall_r   <= ~sck_sync_r[SYNC_STAGES-1] &  sck_level_r;
            ss_fall_r    <= ~ss_sync_r[SYNC_STAGES-1]  &  ss_level_r;
            ss_rise_r    <=  ss_sync_r[SYNC_STAGES-1]  & ~ss_level_r;
        end
    end

    assign sck_rise   = sck_rise_r;
    assign sck_fall   = sck_fall_r;
    assign ss_fall    = ss_fall_r;
    assign ss_rise    = ss_rise_r;
    assign ss_level   = ss_level_r;
    assign mosi_level = mosi_level_r;

endmodule

// File: rtl/spi_image_loader.sv
// SPI slave that receives a framed 12x12x4-bit image, writes it pixel by
// pixel, launches the classifier and returns its result on the next read.
module spi_image_loader
    import spi_loader_pkg::*;
#(
    parameter int NUM_PIX_BYTES = 72,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_image_loader_if.slave bus
);

    localparam logic [6:0] LAST_BYTE = 7'(NUM_PIX_BYTES - 1);

    logic sck_rise_s;
    logic sck_fall_s;
    logic ss_fall_s;
    logic ss_rise_s;
    logic ss_level_s;
    logic mosi_level_s;

    logic [7:0]    rx_shift_r;
    logic [2:0]    bit_cnt_r;
    logic          byte_done_r;

    loader_state_t state_r;
    loader_state_t state_next_s;
    logic [6:0]    byte_cnt_r;
    logic [6:0]    byte_cnt_next_s;
    logic [7:0]    tx_byte_r;
    logic [7:0]    tx_byte_next_s;
    logic          start_next_s;
    logic          frame_err_next_s;
    logic          pix_load_s;
    logic          start_r;
    logic          frame_err_r;

    logic          pix_we_r;
    logic [7:0]    pix_addr_r;
    logic [3:0]    pix_data_r;
    logic [7:0]    pix_byte_r;
    logic          pix_hi_pend_r;

    logic [7:0]    tx_shift_r;
    logic [7:0]    tx_shift_next_s;
    logic          miso_next_s;
    logic          miso_r;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .sck        (bus.SCK),
        .ss         (bus.SS),
        .mosi       (bus.MOSI),
        .sck_rise   (sck_rise_s),
        .sck_fall   (sck_fall_s),
        .ss_fall    (ss_fall_s),
        .ss_rise    (ss_rise_s),
        .ss_level   (ss_level_s),
        .mosi_level (mosi_level_s)
    );

    // Receive shifter: LSB first, so bits enter at the top and move right
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_r  <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            if (ss_rise_s) begin
                // a byte cut short by SS is dropped without notice
                bit_cnt_r <= 3'd0;
            end else if (sck_rise_s && !ss_level_s) begin
                rx_shift_r <= {mosi_level_s, rx_shift_r[7:1]};
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_done_r <= 1'b1;
                end
            end
        end
    end

    // Frame state machine: next state, byte counter, result latch, pulses
    always_comb begin
        state_next_s     = state_r;
        byte_cnt_next_s  = byte_cnt_r;
        tx_byte_next_s   = tx_byte_r;
        start_next_s     = 1'b0;
        frame_err_next_s = 1'b0;
        pix_load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (byte_done_r && (rx_shift_r == START_CMD)) begin
                    state_next_s    = LOAD;
                    byte_cnt_next_s = 7'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (byte_done_r) begin
                    pix_load_s = 1'b1;
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_next_s    = WAIT_END;
                        byte_cnt_next_s = 7'd0;
                    end else begin
                        byte_cnt_next_s = byte_cnt_r + 7'd1;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            WAIT_END: begin
                if (byte_done_r) begin
                    if (rx_shift_r == END_CMD) begin
                        state_next_s = COMPUTE;
                        start_next_s = 1'b1;
                    end else begin
                        state_next_s     = IDLE;
                        frame_err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = WAIT_END;
                end
            end
            COMPUTE: begin
                // a result arriving with a byte takes priority; the byte is dropped
                if (bus.result_valid) begin
                    tx_byte_next_s = {4'h0, bus.result};
                    state_next_s   = READY;
                end else begin
                    state_next_s = COMPUTE;
                end
            end
            READY: begin
                if (byte_done_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = READY;
                end
            end
            default: begin
                state_next_s    = IDLE;
                byte_cnt_next_s = 7'd0;
            end
        endcase
    end

    // Frame state register and its registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            byte_cnt_r  <= 7'd0;
            tx_byte_r   <= 8'h00;
            start_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            byte_cnt_r  <= byte_cnt_next_s;
            tx_byte_r   <= tx_byte_next_s;
            start_r     <= start_next_s;
            frame_err_r <= frame_err_next_s;
        end
    end

    // Pixel writer: each data byte becomes two writes, low nibble first
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_we_r      <= 1'b0;
            pix_addr_r    <= 8'd0;
            pix_data_r    <= 4'd0;
            pix_byte_r    <= 8'h00;
            pix_hi_pend_r <= 1'b0;
        end else if (pix_load_s) begin
            pix_we_r      <= 1'b1;
            pix_addr_r    <= {byte_cnt_r, 1'b0};
            pix_data_r    <= pix_nibble(rx_shift_r, 1'b0);
            pix_byte_r    <= rx_shift_r;
            pix_hi_pend_r <= 1'b1;
        end else if (pix_hi_pend_r) begin
            pix_we_r      <= 1'b1;
            pix_addr_r    <= pix_addr_r + 8'd1;
            pix_data_r    <= pix_nibble(pix_byte_r, 1'b1);
            pix_hi_pend_r <= 1'b0;
        end else begin
            pix_we_r <= 1'b0;
        end
    end

    // Transmit shifter next value: load on SS fall, shift right on SCK fall
    always_comb begin
        tx_shift_next_s = tx_shift_r;
        if (ss_fall_s) begin
            tx_shift_next_s = (state_r == READY) ? tx_byte_r : BUSY_BYTE;
        end else if (sck_fall_s && !ss_level_s) begin
            tx_shift_next_s = {1'b1, tx_shift_r[7:1]};
        end else begin
            tx_shift_next_s = tx_shift_r;
        end
        if (ss_level_s) begin
            miso_next_s = 1'b1;
        end else begin
            miso_next_s = tx_shift_next_s[0];
        end
    end

    // Transmit shifter and registered MISO pin
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= BUSY_BYTE;
            miso_r     <= 1'b1;
        end else begin
            tx_shift_r <= tx_shift_next_s;
            miso_r     <= miso_next_s;
        end
    end

    assign bus.MISO      = miso_r;
    assign bus.pix_we    = pix_we_r;
    assign bus.pix_addr  = pix_addr_r;
    assign bus.pix_data  = pix_data_r;
    assign bus.start     = start_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_image_loader.sv
// Self-checking bench for spi_image_loader: table of whole frames plus
// hand-written reset, abort and out-of-state result sequences. Pixel
// writes are checked against a scoreboard filled as bytes are sent.
module tb_spi_image_loader;
    import spi_loader_pkg::*;

    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_image_loader_if bus();

    spi_image_loader #(
        .NUM_PIX_BYTES (72),
        .SYNC_STAGES   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [3:0] data;
    } pix_t;

    typedef struct {
        logic [7:0]    seed;
        logic [7:0]    step;
        logic [7:0]    term;
        logic [3:0]    res;
        int            exp_start;
        int            exp_err;
        loader_state_t exp_state;
    } frame_vec_t;

    pix_t       exp_q[$];
    pix_t       mon_e;
    frame_vec_t vecs[5];

    int tests     = 0;
    int fails     = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    int pix_cnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pix_we) begin
                pix_cnt++;
                if (exp_q.size() == 0) begin
                    check("pix_unexpected_addr", int'(bus.pix_addr), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_addr", int'(bus.pix_addr), int'(mon_e.addr));
                    check("pix_data", int'(bus.pix_data), int'(mon_e.data));
                end
            end
            if (bus.start) start_cnt++;
            if (bus.frame_err) err_cnt++;
        end
    end

    // One SPI transaction of nbits, LSB first; MISO sampled just before each SCK rise
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        bus.SS = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = tx[i];
            wait_clk(HALF);
            rx[i] = bus.MISO;
            bus.SCK = 1'b1;
            wait_clk(HALF);
            bus.SCK = 1'b0;
        end
        wait_clk(HALF);
        bus.SS   = 1'b1;
        bus.MOSI = 1'b1;
        wait_clk(HALF + 2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] rx;
        spi_xfer(b, 8, rx);
    endtask

    task automatic send_pixel(input logic [7:0] b, input int k);
        exp_q.push_back('{addr: 8'(2 * k),     data: b[3:0]});
        exp_q.push_back('{addr: 8'(2 * k + 1), data: b[7:4]});
        send_byte(b);
    endtask

    task automatic pulse_result(input logic [3:0] r);
        bus.result       = r;
        bus.result_valid = 1'b1;
        wait_clk(1);
        bus.result_valid = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] b;
        int s0;
        int e0;
        int p0;

        vecs[0] = '{8'h21, 8'h00, END_CMD, 4'd7, 1, 0, COMPUTE};
        vecs[1] = '{8'h00, 8'h01, 8'h55,   4'd0, 0, 1, IDLE};
        vecs[2] = '{8'hFF, 8'h00, END_CMD, 4'd9, 1, 0, COMPUTE};
        vecs[3] = '{8'h00, 8'h00, 8'h00,   4'd0, 0, 1, IDLE};
        vecs[4] = '{8'h5A, 8'h03, END_CMD, 4'd0, 1, 0, COMPUTE};

        bus.SCK          = 1'b0;
        bus.SS           = 1'b1;
        bus.MOSI         = 1'b1;
        bus.result_valid = 1'b0;
        bus.result       = 4'd0;
        rst              = 1'b1;
        wait_clk(4);

        // outputs while held in reset
        check("rst_miso",      int'(bus.MISO),      1);
        check("rst_pix_we",    int'(bus.pix_we),    0);
        check("rst_pix_addr",  int'(bus.pix_addr),  0);
        check("rst_pix_data",  int'(bus.pix_data),  0);
        check("rst_start",     int'(bus.start),     0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_state",     int'(dut.state_r),   int'(IDLE));
        rst = 1'b0;
        wait_clk(4);

        // result_valid outside COMPUTE is ignored; reads in IDLE return busy
        pulse_result(4'd3);
        spi_xfer(8'h5A, 8, rx);
        check("idle_read_busy", int'(rx), 8'hFF);
        check("idle_state",     int'(dut.state_r), int'(IDLE));

        // partial byte dropped by SS rise, then a clean start command
        spi_xfer(8'hFF, 5, rx);
        check("abort_state", int'(dut.state_r), int'(IDLE));
        send_byte(START_CMD);
        check("abort_then_start_state", int'(dut.state_r), int'(LOAD));

        // reset in the middle of a frame
        s0 = start_cnt;
        for (int k = 0; k < 30; k++) begin
            send_pixel(8'(k * 7 + 1), k);
        end
        check("midframe_queue_drained", exp_q.size(), 0);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("midframe_rst_state",    int'(dut.state_r),  int'(IDLE));
        check("midframe_rst_pix_addr", int'(bus.pix_addr), 0);
        check("midframe_no_start",     start_cnt - s0,     0);

        // table of whole frames; the first one also proves restart after reset
        for (int v = 0; v < 5; v++) begin
            s0 = start_cnt;
            e0 = err_cnt;
            p0 = pix_cnt;
            send_byte(START_CMD);
            check("frame_load_state", int'(dut.state_r), int'(LOAD));
            for (int k = 0; k < 72; k++) begin
                b = vecs[v].seed + 8'(int'(vecs[v].step) * k);
                send_pixel(b, k);
            end
            check("frame_wait_end_state", int'(dut.state_r), int'(WAIT_END));
            check("frame_queue_drained",  exp_q.size(), 0);
            check("frame_pix_count",      pix_cnt - p0, NUM_PIXELS);
            send_byte(vecs[v].term);
            wait_clk(4);
            check("frame_start_count", start_cnt - s0, vecs[v].exp_start);
            check("frame_err_count",   err_cnt - e0,   vecs[v].exp_err);
            check("frame_end_state",   int'(dut.state_r), int'(vecs[v].exp_state));
            if (vecs[v].exp_state == COMPUTE) begin
                spi_xfer(8'h33, 8, rx);
                check("busy_read_value", int'(rx), 8'hFF);
                check("busy_read_state", int'(dut.state_r), int'(COMPUTE));
                pulse_result(vecs[v].res);
                check("result_ready_state", int'(dut.state_r), int'(READY));
                spi_xfer(8'hFF, 8, rx);
                check("result_read_value", int'(rx), int'({4'h0, vecs[v].res}));
                check("result_read_state", int'(dut.state_r), int'(IDLE));
            end
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
